// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and helpers for the inter-stage pipeline
//                registers of the 5-stage MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // PC value presented after reset (MARS-style text segment base)
   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

   // Default width of the hazard-unit Tnew field
   localparam int TNEW_W_DEF = 2;

   // Bubble control word: a bubble never writes a register and never
   // produces a result the hazard unit must wait for.
   localparam logic       BUBBLE_VALID    = 1'b0;
   localparam logic       BUBBLE_REGWRITE = 1'b0;
   localparam logic [4:0] BUBBLE_REGDST   = 5'd0;

   // Decrement by one, sticking at zero instead of wrapping
   function automatic logic [31:0] sat_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline boundary register with stall hold,
//                flush-to-bubble, valid qualification of the write-back
//                control, saturating Tnew decrement and a stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int          DATA_W           = 64,
   parameter int          TNEW_W           = TNEW_W_DEF,
   parameter bit          TNEW_DEC         = 1'b1,
   parameter logic [31:0] PC_RESET         = PC_RESET_DEF,
   parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
   parameter int          CNT_W            = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [31:0]       pc_i,
   input  logic              regwrite_i,
   input  logic [4:0]        regdst_i,
   input  logic [TNEW_W-1:0] tnew_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [31:0]       pc_o,
   output logic              regwrite_o,
   output logic [4:0]        regdst_o,
   output logic [TNEW_W-1:0] tnew_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              r_valid;
   logic [31:0]       r_pc;
   logic              r_regwrite;
   logic [4:0]        r_regdst;
   logic [TNEW_W-1:0] r_tnew;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [TNEW_W-1:0] w_tnew_next;
   logic [TNEW_W-1:0] w_tnew_load;
   logic [31:0]       w_flush_pc;
   logic [CNT_W-1:0]  w_stall_cnt_inc;

   // Tnew counts down one stage per advance, or is forwarded untouched
   generate
      if (TNEW_DEC) begin : g_tnew_dec
         assign w_tnew_next = TNEW_W'(sat_dec(32'(tnew_i)));
      end else begin : g_tnew_pass
         assign w_tnew_next = tnew_i;
      end
   endgenerate

   // An empty slot must look like "nothing pending" to the hazard unit
   assign w_tnew_load     = valid_i ? w_tnew_next : '0;
   assign w_flush_pc      = KEEP_PC_ON_FLUSH ? pc_i : PC_RESET;
   assign w_stall_cnt_inc = (r_stall_cnt == '1) ? r_stall_cnt
                                                : r_stall_cnt + CNT_W'(1);

   // Stage register update: reset > flush > stall > load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid     <= BUBBLE_VALID;
         r_pc        <= PC_RESET;
         r_regwrite  <= BUBBLE_REGWRITE;
         r_regdst    <= BUBBLE_REGDST;
         r_tnew      <= '0;
         r_data      <= '0;
         r_stall_cnt <= '0;
      end else if (flush_i) begin
         r_valid     <= BUBBLE_VALID;
         r_pc        <= w_flush_pc;
         r_regwrite  <= BUBBLE_REGWRITE;
         r_regdst    <= BUBBLE_REGDST;
         r_tnew      <= '0;
         r_data      <= '0;
      end else if (stall_i) begin
         r_stall_cnt <= w_stall_cnt_inc;
      end else begin
         r_valid     <= valid_i;
         r_pc        <= pc_i;
         r_regwrite  <= regwrite_i & valid_i;
         r_regdst    <= valid_i ? regdst_i : BUBBLE_REGDST;
         r_tnew      <= w_tnew_load;
         r_data      <= data_i;
      end
   end

   assign valid_o     = r_valid;
   assign pc_o        = r_pc;
   assign regwrite_o  = r_regwrite;
   assign regdst_o    = r_regdst;
   assign tnew_o      = r_tnew;
   assign data_o      = r_data;
   assign stall_cnt_o = r_stall_cnt;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed scoreboard bench for pipe_stage_reg. Instance A
//                uses the defaults; instance B clears the PC on flush and
//                has a 2-bit stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] pc_i = 32'd0;
   logic        regwrite_i = 1'b0;
   logic [4:0]  regdst_i = 5'd0;
   logic [1:0]  tnew_i = 2'd0;
   logic [63:0] data_i = 64'd0;

   logic        a_valid, a_rw, b_valid, b_rw;
   logic [31:0] a_pc, b_pc;
   logic [4:0]  a_rd, b_rd;
   logic [1:0]  a_tnew, b_tnew;
   logic [63:0] a_data, b_data;
   logic [15:0] a_cnt;
   logic [1:0]  b_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg u_dut_a (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .pc_i(pc_i), .regwrite_i(regwrite_i),
      .regdst_i(regdst_i), .tnew_i(tnew_i), .data_i(data_i),
      .valid_o(a_valid), .pc_o(a_pc), .regwrite_o(a_rw), .regdst_o(a_rd),
      .tnew_o(a_tnew), .data_o(a_data), .stall_cnt_o(a_cnt)
   );

   pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0), .CNT_W(2)) u_dut_b (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .pc_i(pc_i), .regwrite_i(regwrite_i),
      .regdst_i(regdst_i), .tnew_i(tnew_i), .data_i(data_i),
      .valid_o(b_valid), .pc_o(b_pc), .regwrite_o(b_rw), .regdst_o(b_rd),
      .tnew_o(b_tnew), .data_o(b_data), .stall_cnt_o(b_cnt)
   );

   typedef struct {
      string       tag;
      logic        v;
      logic [31:0] pc;
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  tn;
      logic [63:0] d;
      logic [15:0] cnt;
      logic [31:0] pcb;
      logic [1:0]  cntb;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input string name,
                      input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, req);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the response
   // expected after the following rising edge.
   task automatic step(input string tag, input logic rst, input logic st,
                       input logic fl, input logic vl, input logic [31:0] pc,
                       input logic rw, input logic [4:0] rd, input logic [1:0] tn,
                       input logic [63:0] d,
                       input logic e_v, input logic [31:0] e_pc, input logic e_rw,
                       input logic [4:0] e_rd, input logic [1:0] e_tn,
                       input logic [63:0] e_d, input logic [15:0] e_cnt,
                       input logic [31:0] e_pcb, input logic [1:0] e_cntb);
      exp_t e;
      @(negedge clk);
      reset = rst; stall_i = st; flush_i = fl; valid_i = vl; pc_i = pc;
      regwrite_i = rw; regdst_i = rd; tnew_i = tn; data_i = d;
      e.tag = tag; e.v = e_v; e.pc = e_pc; e.rw = e_rw; e.rd = e_rd;
      e.tn = e_tn; e.d = e_d; e.cnt = e_cnt; e.pcb = e_pcb; e.cntb = e_cntb;
      exp_q.push_back(e);
   endtask

   // Monitor: after each rising edge, compare outputs with the oldest entry
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "valid_o",     64'(a_valid), 64'(e.v));
            chk(e.tag, "pc_o",        64'(a_pc),    64'(e.pc));
            chk(e.tag, "regwrite_o",  64'(a_rw),    64'(e.rw));
            chk(e.tag, "regdst_o",    64'(a_rd),    64'(e.rd));
            chk(e.tag, "tnew_o",      64'(a_tnew),  64'(e.tn));
            chk(e.tag, "data_o",      a_data,       e.d);
            chk(e.tag, "stall_cnt_o", 64'(a_cnt),   64'(e.cnt));
            chk(e.tag, "b.pc_o",      64'(b_pc),    64'(e.pcb));
            chk(e.tag, "b.stall_cnt", 64'(b_cnt),   64'(e.cntb));
            chk(e.tag, "b.valid_o",   64'(b_valid), 64'(e.v));
            chk(e.tag, "b.tnew_o",    64'(b_tnew),  64'(e.tn));
         end
      end
   end

   initial begin
      int waited;
      //   tag          rst st fl vl pc            rw rd     tn    data
      //   exp: v pc rw rd tn data cnt | B: pc cnt
      step("reset",     1, 0, 0, 1, 32'h0000_3004, 1, 5'd3, 2'd2, 64'h5,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd0, 32'h0000_3000, 2'd0);
      step("load_t2",   0, 0, 0, 1, 32'h0000_3008, 1, 5'd8, 2'd2, 64'h1234,
           1, 32'h0000_3008, 1, 5'd8, 2'd1, 64'h1234, 16'd0, 32'h0000_3008, 2'd0);
      step("load_t0",   0, 0, 0, 1, 32'h0000_300C, 1, 5'd9, 2'd0, 64'hDEAD_BEEF,
           1, 32'h0000_300C, 1, 5'd9, 2'd0, 64'hDEAD_BEEF, 16'd0, 32'h0000_300C, 2'd0);
      step("stall1",    0, 1, 0, 1, 32'h0000_3100, 0, 5'd3, 2'd3, 64'h55,
           1, 32'h0000_300C, 1, 5'd9, 2'd0, 64'hDEAD_BEEF, 16'd1, 32'h0000_300C, 2'd1);
      step("stall2",    0, 1, 0, 0, 32'h0000_3104, 1, 5'd4, 2'd1, 64'h66,
           1, 32'h0000_300C, 1, 5'd9, 2'd0, 64'hDEAD_BEEF, 16'd2, 32'h0000_300C, 2'd2);
      step("stall3",    0, 1, 0, 1, 32'h0000_3108, 1, 5'd5, 2'd2, 64'h77,
           1, 32'h0000_300C, 1, 5'd9, 2'd0, 64'hDEAD_BEEF, 16'd3, 32'h0000_300C, 2'd3);
      step("release",   0, 0, 0, 1, 32'h0000_3200, 0, 5'd4, 2'd3, 64'hAAAA,
           1, 32'h0000_3200, 0, 5'd4, 2'd2, 64'hAAAA, 16'd3, 32'h0000_3200, 2'd3);
      step("flush_stl", 0, 1, 1, 1, 32'h0000_3010, 1, 5'd7, 2'd2, 64'hFF,
           0, 32'h0000_3010, 0, 5'd0, 2'd0, 64'h0, 16'd3, 32'h0000_3000, 2'd3);
      step("invalid",   0, 0, 0, 0, 32'h0000_3014, 1, 5'd31, 2'd3, 64'h77,
           0, 32'h0000_3014, 0, 5'd0, 2'd0, 64'h77, 16'd3, 32'h0000_3014, 2'd3);
      step("load_t3",   0, 0, 0, 1, 32'h0000_3018, 1, 5'd1, 2'd3, 64'h1,
           1, 32'h0000_3018, 1, 5'd1, 2'd2, 64'h1, 16'd3, 32'h0000_3018, 2'd3);
      step("reset2",    1, 0, 0, 1, 32'h0000_3020, 1, 5'd2, 2'd2, 64'h2,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd0, 32'h0000_3000, 2'd0);
      step("sat1",      0, 1, 0, 1, 32'h0000_3030, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd1, 32'h0000_3000, 2'd1);
      step("sat2",      0, 1, 0, 1, 32'h0000_3034, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd2, 32'h0000_3000, 2'd2);
      step("sat3",      0, 1, 0, 1, 32'h0000_3038, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd3, 32'h0000_3000, 2'd3);
      step("sat4",      0, 1, 0, 1, 32'h0000_303C, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd4, 32'h0000_3000, 2'd3);
      step("sat5",      0, 1, 0, 1, 32'h0000_3040, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd5, 32'h0000_3000, 2'd3);
      step("rst_stall", 1, 1, 0, 1, 32'h0000_3300, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd0, 32'h0000_3000, 2'd0);
      step("stall_pr",  0, 1, 0, 1, 32'h0000_3304, 1, 5'd6, 2'd1, 64'h3,
           0, 32'h0000_3000, 0, 5'd0, 2'd0, 64'h0, 16'd1, 32'h0000_3000, 2'd1);
      step("load_t1",   0, 0, 0, 1, 32'h0000_3400, 1, 5'd2, 2'd1, 64'h9,
           1, 32'h0000_3400, 1, 5'd2, 2'd0, 64'h9, 16'd1, 32'h0000_3400, 2'd1);
      step("flush",     0, 0, 1, 1, 32'h0000_3500, 1, 5'd3, 2'd3, 64'hB,
           0, 32'h0000_3500, 0, 5'd0, 2'd0, 64'h0, 16'd1, 32'h0000_3000, 2'd1);

      @(negedge clk);
      reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
`default_nettype wire
